mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 6, memory address width.
REQ-002 Parameter DW, default 8, memory data width.
REQ-003 Parameter BURST_MAX, default 4, maximum consecutive granted cycles while the other requester waits; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 clr  input  1  reset; asynchronous, active-high.
REQ-006 req0/req1  input  1 each  access request, requester 0 = processor, requester 1 = loader.
REQ-007 we0/we1  input  1 each  write strobe; meaningful only while the matching gnt is high.
REQ-008 addr0/addr1  input  AW each  access address.
REQ-009 wdata0/wdata1  input  DW each  write data.
REQ-010 gnt0/gnt1  output  1 each  registered grant, one-hot or both low.
REQ-011 rdata  output  DW  read data, equal to mem_rdata at all times.
REQ-012 mem_we  output  1  memory write strobe.
REQ-013 mem_addr  output  AW  memory address.
REQ-014 mem_wdata  output  DW  memory write data.
REQ-015 mem_rdata  input  DW  combinational (asynchronous) memory read data.

Function
REQ-016 FSM states: IDLE, G0 (requester 0 owns the port), G1 (requester 1 owns the port); gnt0 = (state==G0), gnt1 = (state==G1).
REQ-017 While in G0, mem_we/mem_addr/mem_wdata = we0/addr0/wdata0; in G1 the same for requester 1; in IDLE all three are 0.
REQ-018 IDLE transitions: with only reqN high, go to GN; with both high, go to the requester not equal to last_gnt; with neither high, stay in IDLE.
REQ-019 Grant latency: exactly one cycle from req sampled high in IDLE to gnt high.
REQ-020 In GN with reqN low, go to G(other) if the other req is high; otherwise go to IDLE. No idle bubble is inserted on a handover.
REQ-021 In GN with reqN high and the other req low, stay in GN regardless of the beat count.
REQ-022 In GN with both reqs high, stay in GN until beat == BURST_MAX-1, then go to G(other) at the next edge.
REQ-023 beat: 4-bit counter, cleared on every entry into G0/G1 and in IDLE, incremented each granted cycle, saturating at BURST_MAX-1.
REQ-024 last_gnt: 1-bit register, updated to N on every entry into GN, and used only for the IDLE tie-break.
REQ-025 A requester deasserting req while granted loses gnt at the next edge; a transfer in that last granted cycle still completes (mem_we follows weN combinationally).
REQ-026 A requester's we/addr/wdata never reach the memory port while its gnt is low.

Reset
REQ-027 Reset values: state=IDLE, beat=0, last_gnt=1 (so requester 0 wins the first tie); gnt0=gnt1=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-028 Reset asserted mid-burst forces gnt low and mem_we=0 immediately, without waiting for a clock edge.
REQ-029 After reset deasserts, the first grant follows REQ-018 from IDLE.

Structure
REQ-030 A shared package holds the state encoding (IDLE=2'b00, G0=2'b01, G1=2'b10) and the default values of AW and DW.
REQ-031 One sub-module, arb_beat_cnt: a 4-bit counter with asynchronous active-high clear, synchronous clear, enable and saturate limit, instantiated once.
REQ-032 Output muxing is combinational from the registered state; there are no other registers besides state, beat and last_gnt.

Verification
REQ-033 Reset, then req0=1 only with addr0=6'h05, we0=0: gnt0=1 one cycle later, mem_addr=6'h05, rdata=mem_rdata.
REQ-034 From IDLE after reset, req0=req1=1 in the same cycle: gnt0 first; after 4 cycles gnt1=1 and gnt0=0 with no idle cycle; after 4 more cycles gnt0=1 again.
REQ-035 req1=1 alone for 10 cycles with we1=1, addr1 stepping 0..9: gnt1 stays high for all 10 cycles and mem_we=1 for each; no switch occurs.
REQ-036 In G0, drop req0 while req1=1: gnt1=1 at the next edge; with BURST_MAX=1 and both held, gnt alternates every cycle.
REQ-037 Assert clr during G1 with we1=1: gnt1 and mem_we fall without a clock edge; after release with req0=req1=1, gnt0 is granted first.
REQ-038 Random req/we stimulus for 10k cycles: gnt0&gnt1 is never 1, and mem_we=0 whenever both gnts are 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
package mem_arbiter_pkg;

  localparam int unsigned AwDefault = 6;
  localparam int unsigned DwDefault = 8;

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StG0   = 2'b01;
  localparam logic [1:0] StG1   = 2'b10;

  function automatic logic is_grant(input logic [1:0] st);
    return (st == StG0) || (st == StG1);
  endfunction

endpackage

// File: rtl/arb_beat_cnt.sv
// 4-bit beat counter: async clear, sync clear, enable, saturates at limit_i.
module arb_beat_cnt (
  input  logic       clk,
  input  logic       clr,
  input  logic       sclr_i,
  input  logic       en_i,
  input  logic [3:0] limit_i,
  output logic [3:0] cnt_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sclr_i) begin
      cnt_d = 4'd0;
    end else if (en_i && (cnt_q != limit_i)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter with bounded bursts under contention.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW        = AwDefault,
  parameter int unsigned DW        = DwDefault,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] BeatLimit = 4'(BURST_MAX - 1);

  logic [1:0] state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic [3:0] beat;
  logic       beat_last;
  logic       beat_sclr;

  assign beat_last = (beat == BeatLimit);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          // Tie goes to whoever did not own the port last.
          state_d = last_gnt_q ? StG0 : StG1;
        end else if (req0) begin
          state_d = StG0;
        end else if (req1) begin
          state_d = StG1;
        end
      end
      StG0: begin
        if (!req0) begin
          state_d = req1 ? StG1 : StIdle;
        end else if (req1 && beat_last) begin
          state_d = StG1;
        end
      end
      StG1: begin
        if (!req1) begin
          state_d = req0 ? StG0 : StIdle;
        end else if (req0 && beat_last) begin
          state_d = StG0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (state_d != state_q) begin
      if (state_d == StG0) begin
        last_gnt_d = 1'b0;
      end else if (state_d == StG1) begin
        last_gnt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign beat_sclr = (state_d != state_q) || (state_d == StIdle);

  arb_beat_cnt u_beat_cnt (
    .clk     (clk),
    .clr     (clr),
    .sclr_i  (beat_sclr),
    .en_i    (is_grant(state_q)),
    .limit_i (BeatLimit),
    .cnt_o   (beat)
  );

  assign gnt0  = (state_q == StG0);
  assign gnt1  = (state_q == StG1);
  assign rdata = mem_rdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      StG0: begin
        mem_we    = we0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
      end
      StG1: begin
        mem_we    = we1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end
      default: ;
    endcase
  end

endmodule
